window_gen_3x3: RTL and testbench
=================================

// Module: window_gen_3x3
// PURPOSE
//  Builds a sliding 3x3 neighbourhood of 8-bit luma pixels from a raster-scan video stream.
//  Sits directly upstream of the 3x3 neighbourhood filters (median, Sobel, morphology) and
//  feeds them 9 pixels per clock, plus frame/line/valid strobes aligned to those pixels.
//  Out-of-frame window positions read as zero.
// PARAMETERS
//  IMG_WIDTH   640  active pixels per line; sets line-buffer depth
//  DATA_W      8    pixel width in bits
// PORTS
//  clk               in   1       pixel clock; all logic on its rising edge
//  rst_n             in   1       asynchronous, active-low reset
//  pre_frame_vsync   in   1       frame sync, high for the whole frame
//  pre_frame_hsync   in   1       line data enable, high while active pixels are present
//  pre_frame_valid   in   1       pixel strobe; a pixel is accepted only when hsync & valid
//  pre_img_y         in   DATA_W  input pixel
//  matrix_frame_vsync out 1       vsync delayed 2 clk
//  matrix_frame_hsync out 1       hsync delayed 2 clk
//  matrix_frame_valid out 1       (hsync & valid) delayed 2 clk
//  matrix_p11..p33   out  DATA_W  window: p1x = line N-2, p2x = line N-1, p3x = current line N;
//                                 px3 = newest column, px1 = oldest
// BEHAVIOUR
//  - Reset: all outputs, counters, window and delay registers go to 0. RAM contents are
//    not cleared; they are masked (see the row rules below).
//  - Accept = pre_frame_hsync & pre_frame_valid.
//  - col_cnt (clog2(IMG_WIDTH) bits):
//    - increments on each accept; saturates at IMG_WIDTH-1;
//    - clears on the hsync falling edge and on the vsync rising edge.
//  - row_cnt (2 bits, saturates at 2):
//    - increments on each hsync falling edge;
//    - clears on the vsync rising edge.
//  - Two line buffers, LB0 (line N-1) and LB1 (line N-2), each IMG_WIDTH x DATA_W:
//    - on accept, read both at address col_cnt;
//    - cycle later, write the input pixel into LB0 and LB0's read data into LB1, same address;
//    - writes are suppressed once col_cnt has saturated and the line is over-length;
//      in that case the window still shifts.
//  - Pipeline, fixed latency 2 clk from accept to matrix_frame_valid:
//    - stage 1: register the input pixel, accept flag and col_cnt; RAM read data returns;
//    - stage 2: on the stage-1 accept, shift columns left (px1<=px2, px2<=px3) and load
//      p13 = LB1 data, p23 = LB0 data, p33 = pixel.
//    - With no accept, the window holds its value.
//  - Zero masking, applied at stage-2 load:
//    - row_cnt==0: p13 and p23 load 0;
//    - row_cnt==1: p13 loads 0.
//    - Column masking: at col 0 the entire window (px1, px2) clears before the load; at col 1
//      only px1 loads 0. No stale pixels from the previous line therefore leak in.
//  - Strobes: vsync/hsync/accept each pass through a 2-deep shift register. Outputs change
//    only at stage 2, so data and strobes are coincident.
//  - Reset mid-frame: the block restarts clean. Until the next vsync rising edge, row_cnt
//    counts from 0, so unwritten RAM is never exposed.
//  - Simultaneous hsync fall and vsync rise: the vsync clear takes priority (row_cnt=0, col_cnt=0).
//  - Throughput: 1 pixel/clk. Gaps in valid are allowed within a line; each gap inserts a
//    bubble with no reordering.
// STRUCTURE
//  - Shared include: clog2 function and DATA_W default, common to all image stages.
//  - One submodule: lb_ram_sdp, a simple dual-port RAM (1 write port, 1 read port, 1-clk
//    registered read, no reset); two instances.
//  - Counters, masking, window registers and strobe delay stay in the top module.
// TESTING
//  1 Reset then idle: all outputs 0; after rst_n rises with no input, outputs remain 0.
//  2 4x4 frame (IMG_WIDTH=4), pixels = 16*row+col:
//    - line 0, col 2 window: p31..p33 = 0,1,2, rows 1-2 = 0;
//    - line 2, col 3: p11..p33 = 01,02,03 / 11,12,13 / 21,22,23 (hex).
//  3 Latency: single accept at T -> matrix_frame_valid high exactly at T+2, vsync/hsync
//    edges also shifted by exactly 2.
//  4 Valid gaps: a line of 4 pixels with valid pattern 1,0,1,1,0,1 -> window contents
//    identical to the gap-free case; 4 valid outputs.
//  5 Over-length line of 6 pixels at IMG_WIDTH=4:
//    - no RAM writes past col 3;
//    - the next line's p23 column equals the first 4 pixels.
//  6 Reset asserted mid line 2, released, new frame sent: first two lines show zero upper
//    rows, with no data from the aborted frame.

Source files
------------

// File: rtl/window_gen_3x3_pkg.sv
// Shared definitions for the image pipeline stages: default pixel width and a
// constant clog2 used to size counters and RAM addresses.
package window_gen_3x3_pkg;

  localparam int DATA_W_DEF = 8;
  localparam logic [1:0] ROW_MAX = 2'd2;

  // Never returns 0, so a 1-entry buffer still gets a 1-bit address.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/lb_ram_sdp.sv
// Simple dual-port line-buffer RAM: one write port, one registered read port.
// There is no reset, so it maps onto block RAM.
module lb_ram_sdp #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Sliding 3x3 pixel window over a raster stream, built from two line buffers.
// Data and strobes both appear two clocks after the pixel is accepted.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pre_frame_vsync,
  input  logic              pre_frame_hsync,
  input  logic              pre_frame_valid,
  input  logic [DATA_W-1:0] pre_img_y,
  output logic              matrix_frame_vsync,
  output logic              matrix_frame_hsync,
  output logic              matrix_frame_valid,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33
);

  localparam int COL_W = clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);

  logic              accept;
  logic              vsync_d, hsync_d;
  logic              vsync_rise, hsync_fall;
  logic [COL_W-1:0]  col_cnt;
  logic              col_full;
  logic [1:0]        row_cnt;

  logic [DATA_W-1:0] pix_s1;
  logic              acc_s1, wr_s1;
  logic [COL_W-1:0]  col_s1;
  logic              vs_s1, hs_s1, vs_s2, hs_s2, acc_s2;

  logic [DATA_W-1:0] lb0_rdata, lb1_rdata;
  logic [DATA_W-1:0] top_new, mid_new;
  logic              keep_px1, keep_px2;

  assign accept     = pre_frame_hsync & pre_frame_valid;
  assign vsync_rise = pre_frame_vsync & ~vsync_d;
  assign hsync_fall = hsync_d & ~pre_frame_hsync;

  // col_full marks that the last in-range column has been taken, so any
  // further pixels on this line are over-length and must not touch the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      hsync_d  <= 1'b0;
      col_cnt  <= '0;
      col_full <= 1'b0;
      row_cnt  <= '0;
    end else begin
      vsync_d <= pre_frame_vsync;
      hsync_d <= pre_frame_hsync;
      if (vsync_rise) begin
        col_cnt  <= '0;
        col_full <= 1'b0;
        row_cnt  <= '0;
      end else if (hsync_fall) begin
        col_cnt  <= '0;
        col_full <= 1'b0;
        if (row_cnt != ROW_MAX) row_cnt <= row_cnt + 2'd1;
      end else if (accept) begin
        if (col_cnt == COL_MAX) col_full <= 1'b1;
        else                    col_cnt  <= col_cnt + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_s1 <= '0;
      acc_s1 <= 1'b0;
      wr_s1  <= 1'b0;
      col_s1 <= '0;
      vs_s1  <= 1'b0;
      hs_s1  <= 1'b0;
      vs_s2  <= 1'b0;
      hs_s2  <= 1'b0;
      acc_s2 <= 1'b0;
    end else begin
      pix_s1 <= pre_img_y;
      acc_s1 <= accept;
      wr_s1  <= accept & ~col_full;
      col_s1 <= col_cnt;
      vs_s1  <= pre_frame_vsync;
      hs_s1  <= pre_frame_hsync;
      vs_s2  <= vs_s1;
      hs_s2  <= hs_s1;
      acc_s2 <= acc_s1;
    end
  end

  // LB0 holds line N-1; LB1 is fed from LB0's read data, so it holds line N-2.
  lb_ram_sdp #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb0 (
    .clk   (clk),
    .we    (wr_s1),
    .waddr (col_s1),
    .wdata (pix_s1),
    .re    (accept),
    .raddr (col_cnt),
    .rdata (lb0_rdata)
  );

  lb_ram_sdp #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb1 (
    .clk   (clk),
    .we    (wr_s1),
    .waddr (col_s1),
    .wdata (lb0_rdata),
    .re    (accept),
    .raddr (col_cnt),
    .rdata (lb1_rdata)
  );

  // Rows whose line buffer is not yet written this frame read as zero.
  always_comb begin
    top_new  = (row_cnt == ROW_MAX) ? lb1_rdata : '0;
    mid_new  = (row_cnt != 2'd0)    ? lb0_rdata : '0;
    keep_px2 = (col_s1 != '0);
    keep_px1 = (col_s1 > COL_W'(1));
  end

  // Column masking drops the tail of the previous line at the start of each line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
      matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
      matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
    end else if (acc_s1) begin
      matrix_p11 <= keep_px1 ? matrix_p12 : '0;
      matrix_p21 <= keep_px1 ? matrix_p22 : '0;
      matrix_p31 <= keep_px1 ? matrix_p32 : '0;
      matrix_p12 <= keep_px2 ? matrix_p13 : '0;
      matrix_p22 <= keep_px2 ? matrix_p23 : '0;
      matrix_p32 <= keep_px2 ? matrix_p33 : '0;
      matrix_p13 <= top_new;
      matrix_p23 <= mid_new;
      matrix_p33 <= pix_s1;
    end
  end

  assign matrix_frame_vsync = vs_s2;
  assign matrix_frame_hsync = hs_s2;
  assign matrix_frame_valid = acc_s2;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed self-checking bench for window_gen_3x3 at IMG_WIDTH=4, with
// hand-computed 3x3 windows packed as {p11,p12,p13,p21,p22,p23,p31,p32,p33}.
module tb_window_gen_3x3;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pre_frame_vsync = 1'b0;
  logic       pre_frame_hsync = 1'b0;
  logic       pre_frame_valid = 1'b0;
  logic [7:0] pre_img_y = 8'h00;
  logic       matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;

  int errCount = 0;
  int checkCount = 0;
  logic [71:0] win_q[$];

  window_gen_3x3 #(.IMG_WIDTH(W), .DATA_W(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pre_frame_vsync    (pre_frame_vsync),
    .pre_frame_hsync    (pre_frame_hsync),
    .pre_frame_valid    (pre_frame_valid),
    .pre_img_y          (pre_img_y),
    .matrix_frame_vsync (matrix_frame_vsync),
    .matrix_frame_hsync (matrix_frame_hsync),
    .matrix_frame_valid (matrix_frame_valid),
    .matrix_p11 (matrix_p11), .matrix_p12 (matrix_p12), .matrix_p13 (matrix_p13),
    .matrix_p21 (matrix_p21), .matrix_p22 (matrix_p22), .matrix_p23 (matrix_p23),
    .matrix_p31 (matrix_p31), .matrix_p32 (matrix_p32), .matrix_p33 (matrix_p33)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] curWin();
    return {matrix_p11, matrix_p12, matrix_p13,
            matrix_p21, matrix_p22, matrix_p23,
            matrix_p31, matrix_p32, matrix_p33};
  endfunction

  // Every valid output window is captured away from the rising edge.
  always @(negedge clk) begin
    if (matrix_frame_valid) win_q.push_back(curWin());
  end

  function automatic logic [71:0] winAt(input int i);
    if (i < win_q.size()) return win_q[i];
    return {72{1'b1}};
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hs, input logic v,
                               input logic [7:0] y);
    pre_frame_vsync = vs;
    pre_frame_hsync = hs;
    pre_frame_valid = v;
    pre_img_y       = y;
    @(posedge clk);
    #1;
  endtask

  task automatic frameStart();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic frameEnd();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic sendLine(input logic [7:0] base, input int len);
    for (int c = 0; c < len; c++) applyStimulus(1'b1, 1'b1, 1'b1, base + 8'(c));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  // Valid pattern 1,0,1,1,0,1 carrying four pixels; junk on the idle slots.
  task automatic sendGapLine(input logic [7:0] base);
    logic [5:0] pat;
    int c;
    pat = 6'b101101;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      if (pat[5 - i]) begin
        applyStimulus(1'b1, 1'b1, 1'b1, base + 8'(c));
        c++;
      end else begin
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hEE);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and idle.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("rst_win", curWin(), 72'h0);
    checkOutput("rst_strobes", {matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid}, 72'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("idle_win", curWin(), 72'h0);
    checkOutput("idle_strobes", {matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid}, 72'h0);

    // 4x4 frame, pixel = 16*row + col.
    win_q.delete();
    frameStart();
    for (int r = 0; r < 4; r++) sendLine(8'(16 * r), W);
    frameEnd();
    checkOutput("f4_count", 72'(win_q.size()), 72'd16);
    checkOutput("f4_l0c2", winAt(2),  72'h000000_000000_000102);
    checkOutput("f4_l1c0", winAt(4),  72'h000000_000000_000010);
    checkOutput("f4_l2c3", winAt(11), 72'h010203_111213_212223);
    checkOutput("f4_l3c0", winAt(12), 72'h000010_000020_000030);
    checkOutput("f4_l3c1", winAt(13), 72'h001011_002021_003031);

    // Latency of strobes and data.
    win_q.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("lat_vs_t1", 72'(matrix_frame_vsync), 72'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("lat_vs_t2", 72'(matrix_frame_vsync), 72'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
    checkOutput("lat_val_t1", {matrix_frame_hsync, matrix_frame_valid}, 72'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("lat_val_t2", {matrix_frame_hsync, matrix_frame_valid}, 72'd3);
    checkOutput("lat_data", curWin(), 72'h000000_000000_000055);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("lat_val_t3", {matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid}, 72'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("lat_vs_off", 72'(matrix_frame_vsync), 72'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // Valid gaps inside a line.
    win_q.delete();
    frameStart();
    sendGapLine(8'h40);
    sendLine(8'h50, W);
    frameEnd();
    checkOutput("gap_count", 72'(win_q.size()), 72'd8);
    checkOutput("gap_c0", winAt(0), 72'h000000_000000_000040);
    checkOutput("gap_c1", winAt(1), 72'h000000_000000_004041);
    checkOutput("gap_c3", winAt(3), 72'h000000_000000_414243);
    checkOutput("gap_l1c3", winAt(7), 72'h000000_414243_515253);

    // Over-length line: six pixels on a four-wide image.
    win_q.delete();
    frameStart();
    sendLine(8'h60, 6);
    sendLine(8'h70, W);
    frameEnd();
    checkOutput("ovl_count", 72'(win_q.size()), 72'd10);
    checkOutput("ovl_last", winAt(5), 72'h000000_000000_636465);
    for (int c = 0; c < W; c++)
      checkOutput($sformatf("ovl_p23_c%0d", c), 72'(winAt(6 + c)[31:24]), 72'(8'h60 + 8'(c)));
    checkOutput("ovl_l1c3", winAt(9), 72'h000000_616263_717273);

    // Reset in the middle of line 2, then a fresh frame.
    win_q.delete();
    frameStart();
    sendLine(8'h80, W);
    sendLine(8'h90, W);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hC0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hC1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("mid_rst_win", curWin(), 72'h0);
    checkOutput("mid_rst_strobes", {matrix_frame_vsync, matrix_frame_hsync, matrix_frame_valid}, 72'h0);
    rst_n = 1'b1;
    win_q.delete();
    frameStart();
    sendLine(8'hA0, W);
    sendLine(8'hB0, W);
    frameEnd();
    checkOutput("rs_count", 72'(win_q.size()), 72'd8);
    checkOutput("rs_l0c3", winAt(3), 72'h000000_000000_A1A2A3);
    checkOutput("rs_l1c0", winAt(4), 72'h000000_0000A0_0000B0);
    checkOutput("rs_l1c3", winAt(7), 72'h000000_A1A2A3_B1B2B3);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
